mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory-access (MEM) stage of the 5-stage MIPS pipeline. Sits between the EX/MEM register and the writeback stage, and owns the MEM/WB pipeline register.
- Drives a req/ack data-memory interface, performs byte/half/word load alignment with sign/zero extension and store byte-lane steering, and stalls upstream while an access is outstanding.
- Registered outputs feed writeback directly: ReadData, ALUResult, WriteReg, WBControl = {RegWrite, MemtoReg}.

Parameters:
- ADDR_W, 32, width of the data-memory byte address.

Ports:
- clk  in  1  pipeline clock.
- reset  in  1  asynchronous, active-high reset.
- valid_in  in  1  EX/MEM slot holds a real instruction.
- ALUResult_in  in  32  effective address or ALU result.
- StoreData_in  in  32  rt value for stores.
- WriteReg_in  in  5  destination register number.
- WBControl_in  in  2  {RegWrite, MemtoReg}.
- MControl_in  in  5  {MemRead, MemWrite, LoadUnsigned, Size[1:0]}; Size 00=byte, 01=half, 1x=word.
- stall  out  1  hold EX/MEM and earlier stages (combinational).
- mem_req  out  1  memory request (registered).
- mem_we  out  1  1=write, 0=read.
- mem_addr  out  ADDR_W  word-aligned address, addr[1:0]=00.
- mem_wdata  out  32  lane-replicated store data.
- mem_be  out  4  byte enables; bit i = byte lane i, little-endian.
- mem_rdata  in  32  read data, valid when mem_ack=1.
- mem_ack  in  1  access complete; single-cycle pulse.
- ReadData  out  32  aligned, extended load result (MEM/WB).
- ALUResult  out  32  MEM/WB copy of ALUResult_in.
- WriteReg_out  out  5  MEM/WB destination register.
- WBControl_out  out  2  MEM/WB {RegWrite, MemtoReg}.
- valid_out  out  1  MEM/WB slot valid.
- mem_exc  out  1  one-cycle pulse: misaligned or illegal memory op.

Behaviour:
- Reset (async, any state): state=IDLE; all registered outputs 0, including mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadData, ALUResult, WriteReg_out, WBControl_out, valid_out, mem_exc.
- Definitions: memop = valid_in & (MemRead | MemWrite). off = ALUResult_in[1:0].
- Definitions: bad = (MemRead & MemWrite) | (half & off[0]) | (word & off != 00).
- State IDLE:
  - valid_in=0: next edge loads a bubble (valid_out=0, WBControl_out=00, other MEM/WB fields unchanged). stall=0.
  - Non-memop: next edge loads MEM/WB with the inputs, ReadData=0, valid_out=1. stall=0. Latency 1 cycle.
  - memop & bad: no request issued. Next edge loads MEM/WB with WBControl_out=00, valid_out=0, mem_exc=1 for one cycle. stall=0.
  - memop & ~bad: stall=1. Next edge latches the request, sets mem_req=1, and moves to ACCESS.
    - mem_addr = {ALUResult_in[31:2], 00}.
    - mem_we = MemWrite.
    - Byte store: mem_be = 0001 << off; mem_wdata = {4{StoreData_in[7:0]}}.
    - Half store: mem_be = 0011 << off; mem_wdata = {2{StoreData_in[15:0]}}.
    - Word store: mem_be = 1111; mem_wdata = StoreData_in.
    - Reads: mem_be = 1111.
    - Latched with the request: off, Size, LoadUnsigned, WriteReg_in, WBControl_in, ALUResult_in.
- State ACCESS:
  - mem_req, mem_we, mem_addr, mem_be and mem_wdata are held stable until mem_ack.
  - stall = ~mem_ack.
  - Edge with mem_ack=1:
    - mem_req drops to 0; state returns to IDLE.
    - MEM/WB is loaded from the latched fields, valid_out=1.
    - Read: ReadData = lane(off, Size) of mem_rdata, extended. Byte lane = mem_rdata[8*off+7 : 8*off]; half = mem_rdata[16*off[1]+15 : 16*off[1]]. Zero-extend if LoadUnsigned=1, else sign-extend. Word: ReadData = mem_rdata.
    - Write: ReadData = 0.
  - Because stall=0 in the ack cycle, upstream advances on the same edge. The next instruction is evaluated in IDLE on the following cycle, so back-to-back memops have no gap beyond the memory latency.
  - Minimum memop latency: 2 cycles (ack in the first ACCESS cycle).
- mem_ack while in IDLE is ignored.
- mem_rdata is sampled only on the ack edge.
- While stall=1, MEM/WB holds its previous contents, and valid_out remains at its previous value.
- Reset asserted during ACCESS: mem_req deasserts immediately; the in-flight access is abandoned and no MEM/WB write occurs.

Test Plan:
- Non-mem ALU op: ALUResult_in=0x1234, WriteReg_in=5, WBControl_in=10 -> next cycle ALUResult=0x1234, WriteReg_out=5, WBControl_out=10, valid_out=1; stall never asserted.
- LB, addr 0x103, mem_rdata=0x80FF_0000, ack on 3rd ACCESS cycle -> stall high for 3 cycles, mem_addr=0x100, ReadData=0xFFFF_FF80. Repeat with LBU -> ReadData=0x0000_0080.
- SH, addr 0x202, StoreData_in=0xAAAA_BEEF -> mem_we=1, mem_be=1100, mem_wdata=0xBEEF_BEEF, held until ack; then valid_out=1, ReadData=0.
- LW, addr 0x101 -> no mem_req, mem_exc pulses 1 cycle, WBControl_out=00, valid_out=0, stall=0.
- Back-to-back LW 0x10 then SW 0x14, immediate acks -> 2 cycles each. Second mem_req rises the cycle after the first ack; MEM/WB order is preserved.
- Assert reset mid-ACCESS -> mem_req and all outputs go to 0 without a clock edge; after release, state=IDLE and the next memop starts cleanly.

Source files
------------

// File: rtl/mem_stage.sv
// mem_stage: MEM stage of the 5-stage MIPS pipeline.
//   Issues req/ack data-memory accesses, aligns and extends loads, steers store
//   byte lanes, stalls upstream while an access is outstanding and owns the
//   MEM/WB pipeline register.
//
// Ports:
//   clk, reset                 pipeline clock, async active-high reset
//   valid_in, ALUResult_in,    EX/MEM slot contents
//   StoreData_in, WriteReg_in,
//   WBControl_in, MControl_in  MControl = {MemRead, MemWrite, LoadUnsigned, Size[1:0]}
//   stall                      combinational hold request to earlier stages
//   mem_req/we/addr/wdata/be   registered data-memory request
//   mem_rdata, mem_ack         memory response (ack is a one-cycle pulse)
//   ReadData, ALUResult,       MEM/WB register outputs
//   WriteReg_out, WBControl_out,
//   valid_out
//   mem_exc                    one-cycle pulse on misaligned/illegal memory op
//
// State | meaning
// IDLE   | evaluating the EX/MEM slot each cycle
// ACCESS | request outstanding, waiting for mem_ack
module mem_stage #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              valid_in,
  input  logic [31:0]       ALUResult_in,
  input  logic [31:0]       StoreData_in,
  input  logic [4:0]        WriteReg_in,
  input  logic [1:0]        WBControl_in,
  input  logic [4:0]        MControl_in,
  output logic              stall,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic [31:0]       ReadData,
  output logic [31:0]       ALUResult,
  output logic [4:0]        WriteReg_out,
  output logic [1:0]        WBControl_out,
  output logic              valid_out,
  output logic              mem_exc
);

  typedef enum logic {IDLE = 1'b0, ACCESS = 1'b1} state_t;

  state_t              state_q, state_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [31:0]         mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic [31:0]         read_data_q, read_data_d;
  logic [31:0]         alu_result_q, alu_result_d;
  logic [4:0]          write_reg_q, write_reg_d;
  logic [1:0]          wb_ctrl_q, wb_ctrl_d;
  logic                valid_q, valid_d;
  logic                mem_exc_q, mem_exc_d;

  // Fields captured with the request and replayed into MEM/WB on ack.
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                lu_q, lu_d;
  logic [4:0]          wreg_l_q, wreg_l_d;
  logic [1:0]          wbctl_l_q, wbctl_l_d;
  logic [31:0]         alu_l_q, alu_l_d;

  logic       mem_read, mem_write, load_unsigned;
  logic [1:0] size, off;
  logic       is_byte, is_half, is_word;
  logic       memop, bad;

  assign mem_read      = MControl_in[4];
  assign mem_write     = MControl_in[3];
  assign load_unsigned = MControl_in[2];
  assign size          = MControl_in[1:0];
  assign off           = ALUResult_in[1:0];
  assign is_byte       = (size == 2'b00);
  assign is_half       = (size == 2'b01);
  assign is_word       = size[1];

  assign memop = valid_in & (mem_read | mem_write);
  assign bad   = (mem_read & mem_write) | (is_half & off[0]) | (is_word & (off != 2'b00));

  // stall drops in the ack cycle so upstream advances on the same edge.
  assign stall = (state_q == IDLE) ? (memop & ~bad) : ~mem_ack;

  // Load alignment from the latched offset/size.
  logic [31:0] rdata_shift;
  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic [31:0] load_data;

  always_comb begin
    rdata_shift = mem_rdata >> {off_q, 3'b000};
    byte_lane   = rdata_shift[7:0];
    half_lane   = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    load_data   = mem_rdata;
    if (size_q == 2'b00)
      load_data = lu_q ? {24'h0, byte_lane} : {{24{byte_lane[7]}}, byte_lane};
    else if (size_q == 2'b01)
      load_data = lu_q ? {16'h0, half_lane} : {{16{half_lane[15]}}, half_lane};
  end

  always_comb begin
    state_d      = state_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    read_data_d  = read_data_q;
    alu_result_d = alu_result_q;
    write_reg_d  = write_reg_q;
    wb_ctrl_d    = wb_ctrl_q;
    valid_d      = valid_q;
    mem_exc_d    = 1'b0;
    off_d        = off_q;
    size_d       = size_q;
    lu_d         = lu_q;
    wreg_l_d     = wreg_l_q;
    wbctl_l_d    = wbctl_l_q;
    alu_l_d      = alu_l_q;

    case (state_q)
      IDLE: begin
        if (!valid_in) begin
          valid_d   = 1'b0;
          wb_ctrl_d = 2'b00;
        end else if (!memop) begin
          read_data_d  = 32'h0;
          alu_result_d = ALUResult_in;
          write_reg_d  = WriteReg_in;
          wb_ctrl_d    = WBControl_in;
          valid_d      = 1'b1;
        end else if (bad) begin
          wb_ctrl_d = 2'b00;
          valid_d   = 1'b0;
          mem_exc_d = 1'b1;
        end else begin
          // MEM/WB holds while the access is in flight.
          state_d    = ACCESS;
          mem_req_d  = 1'b1;
          mem_we_d   = mem_write;
          mem_addr_d = {ALUResult_in[ADDR_W-1:2], 2'b00};
          mem_be_d   = 4'b1111;
          mem_wdata_d = StoreData_in;
          if (mem_write && is_byte) begin
            mem_be_d    = 4'b0001 << off;
            mem_wdata_d = {4{StoreData_in[7:0]}};
          end else if (mem_write && is_half) begin
            mem_be_d    = 4'b0011 << off;
            mem_wdata_d = {2{StoreData_in[15:0]}};
          end
          off_d     = off;
          size_d    = size;
          lu_d      = load_unsigned;
          wreg_l_d  = WriteReg_in;
          wbctl_l_d = WBControl_in;
          alu_l_d   = ALUResult_in;
        end
      end
      ACCESS: begin
        if (mem_ack) begin
          state_d      = IDLE;
          mem_req_d    = 1'b0;
          read_data_d  = mem_we_q ? 32'h0 : load_data;
          alu_result_d = alu_l_q;
          write_reg_d  = wreg_l_q;
          wb_ctrl_d    = wbctl_l_q;
          valid_d      = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= 32'h0;
      mem_be_q     <= 4'h0;
      read_data_q  <= 32'h0;
      alu_result_q <= 32'h0;
      write_reg_q  <= 5'h0;
      wb_ctrl_q    <= 2'b00;
      valid_q      <= 1'b0;
      mem_exc_q    <= 1'b0;
      off_q        <= 2'b00;
      size_q       <= 2'b00;
      lu_q         <= 1'b0;
      wreg_l_q     <= 5'h0;
      wbctl_l_q    <= 2'b00;
      alu_l_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      read_data_q  <= read_data_d;
      alu_result_q <= alu_result_d;
      write_reg_q  <= write_reg_d;
      wb_ctrl_q    <= wb_ctrl_d;
      valid_q      <= valid_d;
      mem_exc_q    <= mem_exc_d;
      off_q        <= off_d;
      size_q       <= size_d;
      lu_q         <= lu_d;
      wreg_l_q     <= wreg_l_d;
      wbctl_l_q    <= wbctl_l_d;
      alu_l_q      <= alu_l_d;
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = mem_addr_q;
  assign mem_wdata     = mem_wdata_q;
  assign mem_be        = mem_be_q;
  assign ReadData      = read_data_q;
  assign ALUResult     = alu_result_q;
  assign WriteReg_out  = write_reg_q;
  assign WBControl_out = wb_ctrl_q;
  assign valid_out     = valid_q;
  assign mem_exc       = mem_exc_q;

endmodule

// File: tb/tb_mem_stage.sv
// tb_mem_stage: directed bench for mem_stage. Inputs change 1 time unit after
// a rising edge, outputs are sampled 1-2 units after the edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        valid_in = 1'b0;
  logic [31:0] ALUResult_in = '0;
  logic [31:0] StoreData_in = '0;
  logic [4:0]  WriteReg_in = '0;
  logic [1:0]  WBControl_in = '0;
  logic [4:0]  MControl_in = '0;
  logic        stall;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = '0;
  logic        mem_ack = 1'b0;
  logic [31:0] ReadData;
  logic [31:0] ALUResult;
  logic [4:0]  WriteReg_out;
  logic [1:0]  WBControl_out;
  logic        valid_out;
  logic        mem_exc;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .ALUResult_in(ALUResult_in),
    .StoreData_in(StoreData_in), .WriteReg_in(WriteReg_in), .WBControl_in(WBControl_in),
    .MControl_in(MControl_in), .stall(stall), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_rdata(mem_rdata),
    .mem_ack(mem_ack), .ReadData(ReadData), .ALUResult(ALUResult),
    .WriteReg_out(WriteReg_out), .WBControl_out(WBControl_out), .valid_out(valid_out),
    .mem_exc(mem_exc)
  );

  // Drives one legal memop (called 1 unit after a rising edge), acks on the
  // ack_after-th ACCESS cycle and reports what the request looked like.
  task automatic run_memop(input logic [31:0] alu, input logic [31:0] sd,
                           input logic [4:0] mc, input logic [4:0] wr,
                           input logic [1:0] wb, input int ack_after,
                           input logic [31:0] rdata,
                           output int stall_cycles, output logic req_seen,
                           output logic [31:0] addr_seen, output logic [31:0] wdata_seen,
                           output logic we_seen, output logic [3:0] be_seen,
                           output logic held, output logic [4:0] wr_during);
    valid_in = 1'b1; ALUResult_in = alu; StoreData_in = sd;
    MControl_in = mc; WriteReg_in = wr; WBControl_in = wb;
    stall_cycles = 0;
    held = 1'b1;
    #1;
    if (stall) stall_cycles++;
    @(posedge clk); #1;
    req_seen = mem_req; addr_seen = mem_addr; wdata_seen = mem_wdata;
    we_seen = mem_we; be_seen = mem_be; wr_during = WriteReg_out;
    for (int k = 1; k <= ack_after; k++) begin
      if (k == ack_after) begin
        mem_ack = 1'b1; mem_rdata = rdata;
      end else begin
        mem_rdata = ~rdata;
      end
      #1;
      if (stall) stall_cycles++;
      if (mem_req !== req_seen || mem_addr !== addr_seen || mem_wdata !== wdata_seen ||
          mem_we !== we_seen || mem_be !== be_seen || WriteReg_out !== wr_during)
        held = 1'b0;
      @(posedge clk); #1;
    end
    mem_ack = 1'b0;
    mem_rdata = 32'h0;
    valid_in = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadData, ALUResult,
         WriteReg_out, WBControl_out, valid_out, mem_exc} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got req=%b addr=%h rd=%h alu=%h valid=%b exc=%b required all 0",
               mem_req, mem_addr, ReadData, ALUResult, valid_out, mem_exc);
    end
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL reset_stall got %b required 0", stall);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_bubble_and_idle_ack();
    valid_in = 1'b0; mem_ack = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    checks++;
    if (mem_req !== 1'b0 || valid_out !== 1'b0 || ReadData !== 32'h0) begin
      errors++;
      $display("FAIL idle_ack got req=%b valid=%b rd=%h required 0 0 00000000",
               mem_req, valid_out, ReadData);
    end
  endtask

  task automatic test_alu_op();
    valid_in = 1'b1; ALUResult_in = 32'h1234; WriteReg_in = 5'd5;
    WBControl_in = 2'b10; MControl_in = 5'b00000;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL alu_stall got %b required 0", stall);
    end
    @(posedge clk); #1;
    checks++;
    if (ALUResult !== 32'h1234 || WriteReg_out !== 5'd5 || WBControl_out !== 2'b10 ||
        valid_out !== 1'b1 || ReadData !== 32'h0 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL alu_op got alu=%h wr=%0d wb=%b valid=%b rd=%h req=%b required 00001234 5 10 1 00000000 0",
               ALUResult, WriteReg_out, WBControl_out, valid_out, ReadData, mem_req);
    end
    valid_in = 1'b0;
  endtask

  task automatic test_lb_lbu();
    int sc; logic rq, we, hd; logic [31:0] ad, wd; logic [3:0] be; logic [4:0] wdur;
    run_memop(32'h103, 32'h0, 5'b10000, 5'd7, 2'b11, 3, 32'h80FF_0000,
              sc, rq, ad, wd, we, be, hd, wdur);
    checks++;
    if (sc != 3) begin errors++; $display("FAIL lb_stall_cycles got %0d required 3", sc); end
    checks++;
    if (rq !== 1'b1 || ad !== 32'h100 || we !== 1'b0 || be !== 4'b1111 || hd !== 1'b1) begin
      errors++;
      $display("FAIL lb_request got req=%b addr=%h we=%b be=%b held=%b required 1 00000100 0 1111 1",
               rq, ad, we, be, hd);
    end
    checks++;
    if (ReadData !== 32'hFFFF_FF80 || valid_out !== 1'b1 || WriteReg_out !== 5'd7 ||
        WBControl_out !== 2'b11 || ALUResult !== 32'h103 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL lb_result got rd=%h valid=%b wr=%0d wb=%b alu=%h req=%b required ffffff80 1 7 11 00000103 0",
               ReadData, valid_out, WriteReg_out, WBControl_out, ALUResult, mem_req);
    end
    run_memop(32'h103, 32'h0, 5'b10100, 5'd7, 2'b11, 3, 32'h80FF_0000,
              sc, rq, ad, wd, we, be, hd, wdur);
    checks++;
    if (ReadData !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu_result got %h required 00000080", ReadData);
    end
  endtask

  task automatic test_lh_lhu();
    int sc; logic rq, we, hd; logic [31:0] ad, wd; logic [3:0] be; logic [4:0] wdur;
    run_memop(32'h302, 32'h0, 5'b10001, 5'd3, 2'b11, 1, 32'h8001_1234,
              sc, rq, ad, wd, we, be, hd, wdur);
    checks++;
    if (ReadData !== 32'hFFFF_8001 || ad !== 32'h300) begin
      errors++; $display("FAIL lh_result got rd=%h addr=%h required ffff8001 00000300", ReadData, ad);
    end
    run_memop(32'h300, 32'h0, 5'b10101, 5'd3, 2'b11, 1, 32'h8001_9234,
              sc, rq, ad, wd, we, be, hd, wdur);
    checks++;
    if (ReadData !== 32'h0000_9234) begin
      errors++; $display("FAIL lhu_result got %h required 00009234", ReadData);
    end
  endtask

  task automatic test_stores();
    int sc; logic rq, we, hd; logic [31:0] ad, wd; logic [3:0] be; logic [4:0] wdur;
    run_memop(32'h202, 32'hAAAA_BEEF, 5'b01001, 5'd0, 2'b00, 2, 32'hDEAD_BEEF,
              sc, rq, ad, wd, we, be, hd, wdur);
    checks++;
    if (rq !== 1'b1 || we !== 1'b1 || ad !== 32'h200 || be !== 4'b1100 ||
        wd !== 32'hBEEF_BEEF || hd !== 1'b1) begin
      errors++;
      $display("FAIL sh_request got req=%b we=%b addr=%h be=%b wdata=%h held=%b required 1 1 00000200 1100 beefbeef 1",
               rq, we, ad, be, wd, hd);
    end
    checks++;
    if (valid_out !== 1'b1 || ReadData !== 32'h0 || sc != 2) begin
      errors++;
      $display("FAIL sh_result got valid=%b rd=%h stall_cycles=%0d required 1 00000000 2",
               valid_out, ReadData, sc);
    end
    run_memop(32'h405, 32'h1234_5678, 5'b01000, 5'd0, 2'b00, 1, 32'h0,
              sc, rq, ad, wd, we, be, hd, wdur);
    checks++;
    if (be !== 4'b0010 || wd !== 32'h7878_7878 || ad !== 32'h404) begin
      errors++;
      $display("FAIL sb_request got be=%b wdata=%h addr=%h required 0010 78787878 00000404",
               be, wd, ad);
    end
  endtask

  task automatic test_misaligned();
    valid_in = 1'b1; ALUResult_in = 32'h101; MControl_in = 5'b10010;
    WriteReg_in = 5'd4; WBControl_in = 2'b11;
    #1;
    checks++;
    if (stall !== 1'b0) begin errors++; $display("FAIL lw_bad_stall got %b required 0", stall); end
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b0 || mem_exc !== 1'b1 || WBControl_out !== 2'b00 || valid_out !== 1'b0) begin
      errors++;
      $display("FAIL lw_bad got req=%b exc=%b wb=%b valid=%b required 0 1 00 0",
               mem_req, mem_exc, WBControl_out, valid_out);
    end
    valid_in = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (mem_exc !== 1'b0) begin errors++; $display("FAIL exc_pulse got %b required 0", mem_exc); end
  endtask

  task automatic test_back_to_back();
    int sc; logic rq, we, hd; logic [31:0] ad, wd; logic [3:0] be; logic [4:0] wdur;
    run_memop(32'h10, 32'h0, 5'b10010, 5'd8, 2'b11, 1, 32'h1122_3344,
              sc, rq, ad, wd, we, be, hd, wdur);
    checks++;
    if (sc != 1 || ReadData !== 32'h1122_3344 || WriteReg_out !== 5'd8 ||
        valid_out !== 1'b1 || mem_req !== 1'b0) begin
      errors++;
      $display("FAIL b2b_lw got stall_cycles=%0d rd=%h wr=%0d valid=%b req=%b required 1 11223344 8 1 0",
               sc, ReadData, WriteReg_out, valid_out, mem_req);
    end
    run_memop(32'h14, 32'hCAFE_F00D, 5'b01010, 5'd9, 2'b00, 1, 32'h0,
              sc, rq, ad, wd, we, be, hd, wdur);
    checks++;
    if (rq !== 1'b1 || ad !== 32'h14 || we !== 1'b1 || be !== 4'b1111 ||
        wd !== 32'hCAFE_F00D || wdur !== 5'd8) begin
      errors++;
      $display("FAIL b2b_sw_req got req=%b addr=%h we=%b be=%b wdata=%h wr_during=%0d required 1 00000014 1 1111 cafef00d 8",
               rq, ad, we, be, wd, wdur);
    end
    checks++;
    if (sc != 1 || WriteReg_out !== 5'd9 || ReadData !== 32'h0 || ALUResult !== 32'h14 ||
        WBControl_out !== 2'b00 || valid_out !== 1'b1) begin
      errors++;
      $display("FAIL b2b_sw got stall_cycles=%0d wr=%0d rd=%h alu=%h wb=%b valid=%b required 1 9 00000000 00000014 00 1",
               sc, WriteReg_out, ReadData, ALUResult, WBControl_out, valid_out);
    end
  endtask

  task automatic test_reset_mid_access();
    int sc; logic rq, we, hd; logic [31:0] ad, wd; logic [3:0] be; logic [4:0] wdur;
    valid_in = 1'b1; ALUResult_in = 32'h40; MControl_in = 5'b10010;
    WriteReg_in = 5'd6; WBControl_in = 2'b11;
    @(posedge clk); #1;
    checks++;
    if (mem_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req got %b required 1", mem_req); end
    valid_in = 1'b0;
    #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({mem_req, mem_we, mem_addr, mem_wdata, mem_be, ReadData, ALUResult,
         WriteReg_out, WBControl_out, valid_out, mem_exc} !== '0) begin
      errors++;
      $display("FAIL rst_mid_access got req=%b addr=%h be=%b alu=%h wr=%0d valid=%b required all 0",
               mem_req, mem_addr, mem_be, ALUResult, WriteReg_out, valid_out);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    run_memop(32'h44, 32'h0, 5'b10010, 5'd2, 2'b11, 1, 32'h0000_0055,
              sc, rq, ad, wd, we, be, hd, wdur);
    checks++;
    if (rq !== 1'b1 || ad !== 32'h44 || ReadData !== 32'h55 || WriteReg_out !== 5'd2 ||
        valid_out !== 1'b1) begin
      errors++;
      $display("FAIL rst_recover got req=%b addr=%h rd=%h wr=%0d valid=%b required 1 00000044 00000055 2 1",
               rq, ad, ReadData, WriteReg_out, valid_out);
    end
  endtask

  initial begin
    test_reset();
    test_bubble_and_idle_ack();
    test_alu_op();
    test_lb_lbu();
    test_lh_lhu();
    test_stores();
    test_misaligned();
    test_back_to_back();
    test_reset_mid_access();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
